// File: rtl/ddr3_rd_arbiter.sv
// Round-robin arbiter and sequencer that gives two readout requesters exclusive,
// one-at-a-time use of the DDR3 read controller, with a watchdog on hung reads.
module ddr3_rd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_enable,
  input  logic [22:0] req0_start_addr,
  input  logic [23:0] req0_burst_cnt,
  output logic        req0_done,
  input  logic        req1_enable,
  input  logic [22:0] req1_start_addr,
  input  logic [23:0] req1_burst_cnt,
  output logic        req1_done,
  output logic [22:0] ddr3_rd_start_addr,
  output logic [23:0] ddr3_rd_burst_cnt,
  output logic        enable_reading,
  input  logic        reading_done,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  input  logic        clear_err
);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    GRANT     = 4'b0010,
    WAIT_DONE = 4'b0100,
    RELEASE   = 4'b1000
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic        r_last_grant, w_last_grant_nxt;
  logic [22:0] r_addr, w_addr_nxt;
  logic [23:0] r_burst, w_burst_nxt;
  logic        r_enable_reading, w_enable_reading_nxt;
  logic [1:0]  r_done, w_done_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_timeout_err, w_timeout_err_nxt;
  logic [23:0] r_wdog, w_wdog_nxt;

  (* ASYNC_REG = "TRUE" *) logic r_done_meta;
  (* ASYNC_REG = "TRUE" *) logic r_done_sync;

  logic        w_pick;
  logic        w_owner_en;
  logic [23:0] w_wdog_inc;
  logic        w_timeout_hit;

  // On a tie the requester that did not win last time is chosen.
  assign w_pick        = (req0_enable && req1_enable) ? ~r_last_grant : req1_enable;
  assign w_owner_en    = |(r_grant & {req1_enable, req0_enable});
  assign w_wdog_inc    = r_wdog + 24'd1;
  assign w_timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (w_wdog_inc == TIMEOUT_CYCLES);

  // Two-stage synchronizer for the reader's completion flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
    end else begin
      r_done_meta <= reading_done;
      r_done_sync <= r_done_meta;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_grant          <= 2'b00;
      r_last_grant     <= 1'b1;
      r_addr           <= 23'd0;
      r_burst          <= 24'd0;
      r_enable_reading <= 1'b0;
      r_done           <= 2'b00;
      r_busy           <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_wdog           <= 24'd0;
    end else begin
      r_state          <= w_state_nxt;
      r_grant          <= w_grant_nxt;
      r_last_grant     <= w_last_grant_nxt;
      r_addr           <= w_addr_nxt;
      r_burst          <= w_burst_nxt;
      r_enable_reading <= w_enable_reading_nxt;
      r_done           <= w_done_nxt;
      r_busy           <= w_busy_nxt;
      r_timeout_err    <= w_timeout_err_nxt;
      r_wdog           <= w_wdog_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt          = r_state;
    w_grant_nxt          = r_grant;
    w_last_grant_nxt     = r_last_grant;
    w_addr_nxt           = r_addr;
    w_burst_nxt          = r_burst;
    w_enable_reading_nxt = r_enable_reading;
    w_done_nxt           = r_done;
    w_busy_nxt           = r_busy;
    w_wdog_nxt           = r_wdog;
    if (clear_err) begin
      w_timeout_err_nxt = 1'b0;
    end else begin
      w_timeout_err_nxt = r_timeout_err;
    end

    case (r_state)
      IDLE: begin
        if (req0_enable || req1_enable) begin
          w_grant_nxt      = w_pick ? 2'b10 : 2'b01;
          w_last_grant_nxt = w_pick;
          w_addr_nxt       = w_pick ? req1_start_addr : req0_start_addr;
          w_burst_nxt      = w_pick ? req1_burst_cnt : req0_burst_cnt;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        w_wdog_nxt = 24'd0;
        if (r_burst == 24'd0) begin
          w_done_nxt  = r_grant;
          w_state_nxt = RELEASE;
        end else begin
          w_enable_reading_nxt = 1'b1;
          w_state_nxt          = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        w_wdog_nxt = w_wdog_inc;
        if (!w_owner_en) begin
          w_enable_reading_nxt = 1'b0;
          w_state_nxt          = RELEASE;
        end else if (r_done_sync) begin
          w_done_nxt  = r_grant;
          w_state_nxt = RELEASE;
        end else if (w_timeout_hit) begin
          w_timeout_err_nxt    = 1'b1;
          w_done_nxt           = r_grant;
          w_enable_reading_nxt = 1'b0;
          w_state_nxt          = RELEASE;
        end else begin
          w_state_nxt = WAIT_DONE;
        end
      end
      RELEASE: begin
        // Grant is kept until the reader's done flag has fallen, so it is re-armed.
        if (!w_owner_en) begin
          w_enable_reading_nxt = 1'b0;
          w_done_nxt           = 2'b00;
          if (!r_done_sync) begin
            w_grant_nxt = 2'b00;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else begin
          w_state_nxt = RELEASE;
        end
      end
      default: begin
        w_state_nxt          = IDLE;
        w_grant_nxt          = 2'b00;
        w_enable_reading_nxt = 1'b0;
        w_done_nxt           = 2'b00;
        w_busy_nxt           = 1'b0;
      end
    endcase
  end

  assign grant              = r_grant;
  assign busy               = r_busy;
  assign enable_reading     = r_enable_reading;
  assign req0_done          = r_done[0];
  assign req1_done          = r_done[1];
  assign ddr3_rd_start_addr = r_addr;
  assign ddr3_rd_burst_cnt  = r_burst;
  assign timeout_err        = r_timeout_err;

endmodule
